mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates a single shared memory port between instruction fetch (IF) and data access (MEM) in the multicycle RISC-V core.
- Drives the SEL of the port's 2:1 address/data mux and sequences each transfer with a valid/ready handshake.
- Returns read data and acknowledges to the winning requester.
- Bounds every transfer with a wait-state timeout.

Parameters:
- MAX_WAIT, 15: maximum cycles in BUSY with Mem_Ready low before abort; legal range 1..255.
- DATA_W, 32: address and data width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  synchronous, active-low reset.
- IF_Req  in  1  fetch request; held with IF_Addr stable until IF_Ack.
- IF_Addr  in  DATA_W  fetch address.
- IF_Ack  out  1  one-cycle pulse: fetch complete.
- IF_Data  out  DATA_W  fetched word.
- MEM_Req  in  1  data request; held with MEM_* stable until MEM_Ack.
- MEM_We  in  1  1 = store, 0 = load.
- MEM_Addr  in  DATA_W  data address.
- MEM_WData  in  DATA_W  store data.
- MEM_Ack  out  1  one-cycle pulse: data access complete.
- MEM_RData  out  DATA_W  load result.
- Mem_Sel  out  1  mux select; 0 = IF, 1 = MEM.
- Mem_Valid  out  1  request to memory.
- Mem_Addr  out  DATA_W  muxed address.
- Mem_WData  out  DATA_W  equals MEM_WData.
- Mem_We  out  1  write enable.
- Mem_Ready  in  1  memory completes the transfer this cycle.
- Mem_RData  in  DATA_W  memory read data, valid when Mem_Ready = 1.
- Err  out  1  one-cycle pulse with Ack on a timeout abort.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (RST_N low at an edge):
  - State goes to IDLE.
  - Mem_Sel, Mem_Valid, IF_Ack, MEM_Ack and Err go to 0.
  - IF_Data, MEM_RData, wait counter and streak counter go to 0.
- IDLE:
  - No request: stay in IDLE; Mem_Sel holds its last value.
  - Only one request: grant it.
  - Both requests: grant MEM, unless the streak counter is 2, in which case grant IF.
  - On a grant: register Mem_Sel, go to BUSY, clear the wait counter.
- Streak counter (2 bits, saturating):
  - Increments on each MEM grant made while IF_Req = 1.
  - Clears on any IF grant.
- BUSY:
  - Mem_Valid = 1.
  - Mem_Addr is combinational: IF_Addr when Mem_Sel = 0, MEM_Addr when Mem_Sel = 1.
  - Mem_We = Mem_Valid & Mem_Sel & MEM_We.
  - Mem_Ready = 1: capture Mem_RData into IF_Data or MEM_RData per Mem_Sel (stores also capture, value is don't-care); go to DONE.
  - Mem_Ready = 0: increment the wait counter. When the counter reaches MAX_WAIT, go to DONE with the abort flag set; the selected data register loads 0.
- DONE (exactly one cycle):
  - Mem_Valid = 0.
  - The selected Ack = 1; Err = abort flag.
  - Next state is always IDLE.
  - Requesters drop Req on the cycle after Ack; a Req still high in IDLE starts a new transfer.
- Latency and throughput:
  - Minimum: Req seen in IDLE at cycle 0, Mem_Valid at cycle 1, Mem_Ready at cycle 1, Ack at cycle 2.
  - Peak throughput: one transfer per 3 cycles.
- Outputs are registered except Mem_Addr, Mem_WData and Mem_We.
- Mem_Ready while not in BUSY is ignored.
- A Req dropped mid-BUSY does not abort the transfer; Ack still pulses.
- Reset mid-BUSY: no Ack, no Err. Mem_Valid is 0 in the cycle after the reset edge.
- IF_Data and MEM_RData hold their values between transfers.

Test Plan:
- Reset, then IF_Req = 1, IF_Addr = 0x00000040, Mem_Ready = 1 immediately, Mem_RData = 0x00A00093 -> Mem_Sel = 0, Mem_Valid high for 1 cycle, IF_Ack at cycle 2, IF_Data = 0x00A00093, Err = 0.
- MEM store, MEM_Addr = 0x100, MEM_WData = 0xDEADBEEF, Mem_Ready delayed 3 cycles -> Mem_Sel = 1, Mem_We = 1 for 4 cycles, MEM_Ack 1 cycle after Ready.
- IF_Req and MEM_Req held continuously, Mem_Ready = 1 -> grant order MEM, MEM, IF, MEM, MEM, IF; each Ack is a single cycle.
- MAX_WAIT = 15, Mem_Ready never asserted on an IF fetch -> Mem_Valid high for exactly 15 cycles, then IF_Ack = 1 and Err = 1 in the same cycle, IF_Data = 0.
- RST_N low during BUSY at cycle 2 of a wait -> Mem_Valid = 0 next cycle, no Ack, all outputs 0. After release, pending IF_Req is granted normally.
- Mem_Ready pulsed while IDLE, and Mem_RData changing between transfers -> no Ack, IF_Data and MEM_RData unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter for the multicycle core: grants IF or MEM access,
// runs one valid/ready transfer at a time and aborts transfers that wait too long.
module mem_port_arbiter #(
    parameter int unsigned MAX_WAIT = 15,   // legal range 1..255
    parameter int unsigned DATA_W   = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IF_Req,
    input  logic [DATA_W-1:0] IF_Addr,
    output logic              IF_Ack,
    output logic [DATA_W-1:0] IF_Data,
    input  logic              MEM_Req,
    input  logic              MEM_We,
    input  logic [DATA_W-1:0] MEM_Addr,
    input  logic [DATA_W-1:0] MEM_WData,
    output logic              MEM_Ack,
    output logic [DATA_W-1:0] MEM_RData,
    output logic              Mem_Sel,
    output logic              Mem_Valid,
    output logic [DATA_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_WData,
    output logic              Mem_We,
    input  logic              Mem_Ready,
    input  logic [DATA_W-1:0] Mem_RData,
    output logic              Err
);

    localparam int unsigned WAIT_W   = 8;
    localparam int unsigned STREAK_W = 2;

    localparam logic [WAIT_W-1:0]   WAIT_LAST   = WAIT_W'(MAX_WAIT - 1);
    localparam logic [STREAK_W-1:0] STREAK_FAIR = STREAK_W'(2);
    localparam logic [STREAK_W-1:0] STREAK_MAX  = STREAK_W'(3);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e              state_q,     state_d;
    logic                sel_q,       sel_d;
    logic                valid_q,     valid_d;
    logic                if_ack_q,    if_ack_d;
    logic                mem_ack_q,   mem_ack_d;
    logic                err_q,       err_d;
    logic [WAIT_W-1:0]   wait_q,      wait_d;
    logic [STREAK_W-1:0] streak_q,    streak_d;
    logic [DATA_W-1:0]   if_data_q,   if_data_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;

    logic grant_c;
    logic grant_mem_c;
    logic finish_c;
    logic timeout_c;

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            sel_q       <= 1'b0;
            valid_q     <= 1'b0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            err_q       <= 1'b0;
            wait_q      <= '0;
            streak_q    <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            valid_q     <= valid_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            err_q       <= err_d;
            wait_q      <= wait_d;
            streak_q    <= streak_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Next state: arbitration in IDLE, completion or timeout in BUSY
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        grant_c     = 1'b0;
        grant_mem_c = 1'b0;
        finish_c    = 1'b0;
        timeout_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (IF_Req || MEM_Req) begin
                    grant_c     = 1'b1;
                    // MEM wins ties until it has won twice in a row over a waiting IF
                    grant_mem_c = MEM_Req && !(IF_Req && (streak_q == STREAK_FAIR));
                    state_d     = ST_BUSY;
                    wait_d      = '0;
                end
            end
            ST_BUSY: begin
                if (Mem_Ready) begin
                    finish_c = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                    if (wait_q == WAIT_LAST) begin
                        timeout_c = 1'b1;
                        finish_c  = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, streak counter and data capture
    always_comb begin
        sel_d       = sel_q;
        streak_d    = streak_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        valid_d     = (state_d == ST_BUSY);
        if_ack_d    = finish_c & ~sel_q;
        mem_ack_d   = finish_c & sel_q;
        err_d       = timeout_c;

        if (grant_c) begin
            sel_d = grant_mem_c;
            if (!grant_mem_c) begin
                streak_d = '0;
            end else if (IF_Req && (streak_q != STREAK_MAX)) begin
                streak_d = streak_q + STREAK_W'(1);
            end
        end

        // An aborted transfer returns zero to the requester
        if (finish_c) begin
            if (sel_q) begin
                mem_rdata_d = timeout_c ? '0 : Mem_RData;
            end else begin
                if_data_d = timeout_c ? '0 : Mem_RData;
            end
        end
    end

    assign Mem_Addr  = sel_q ? MEM_Addr : IF_Addr;
    assign Mem_WData = MEM_WData;
    assign Mem_We    = valid_q & sel_q & MEM_We;

    assign Mem_Sel   = sel_q;
    assign Mem_Valid = valid_q;
    assign IF_Ack    = if_ack_q;
    assign MEM_Ack   = mem_ack_q;
    assign Err       = err_q;
    assign IF_Data   = if_data_q;
    assign MEM_RData = mem_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts grants,
// ack times and returned data; a memory responder and an ack monitor check the DUT.
module tb_mem_port_arbiter;

    localparam int unsigned DW   = 32;
    localparam int unsigned MAXW = 15;
    localparam int          NT   = 1024;

    logic          CLK, RST_N;
    logic          IF_Req, IF_Ack, MEM_Req, MEM_We, MEM_Ack;
    logic [DW-1:0] IF_Addr, IF_Data, MEM_Addr, MEM_WData, MEM_RData;
    logic          Mem_Sel, Mem_Valid, Mem_We, Mem_Ready, Err;
    logic [DW-1:0] Mem_Addr, Mem_WData, Mem_RData;

    mem_port_arbiter #(.MAX_WAIT(MAXW), .DATA_W(DW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Ack(IF_Ack), .IF_Data(IF_Data),
        .MEM_Req(MEM_Req), .MEM_We(MEM_We), .MEM_Addr(MEM_Addr), .MEM_WData(MEM_WData),
        .MEM_Ack(MEM_Ack), .MEM_RData(MEM_RData),
        .Mem_Sel(Mem_Sel), .Mem_Valid(Mem_Valid), .Mem_Addr(Mem_Addr),
        .Mem_WData(Mem_WData), .Mem_We(Mem_We), .Mem_Ready(Mem_Ready),
        .Mem_RData(Mem_RData), .Err(Err)
    );

    typedef struct packed {
        logic        is_mem;
        logic        err;
        logic [31:0] data;
        int          cyc;
    } ack_t;

    typedef struct packed {
        logic        sel;
        logic [31:0] addr;
        logic        we;
        int          start;
        int          busy;
    } acc_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } mreq_t;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ack_t exp_q[$];
    acc_t acc_q[$];
    int          lat_a[NT];
    logic [31:0] rdat_a[NT];
    int   k_model = 0;
    int   k_resp  = 0;
    bit   mon_en  = 0;
    bit   resp_en = 0;
    logic [31:0] exp_if_data, exp_mem_data;

    // Requester and arbitration model state
    logic [31:0] if_scr[$];
    mreq_t       mem_scr[$];
    bit          if_act, mem_act, if_gr, mem_gr, if_req_drv, mem_req_drv;
    int          if_ack_c, mem_ack_c;
    logic [31:0] if_addr_r;
    mreq_t       mem_r;
    bit          rand_en = 0;
    int          p_if = 60;
    int          p_mem = 50;
    int          streak = 0;
    int          next_free = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    function automatic int rand_lat();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 50) return 0;
        if (r < 85) return int'($urandom_range(1, 4));
        if (r < 93) return int'($urandom_range(10, 14));
        return int'($urandom_range(15, 20));
    endfunction

    function automatic void set_xfer(input int off, input int l, input logic [31:0] d);
        lat_a[(k_model + off) % NT]  = l;
        rdat_a[(k_model + off) % NT] = d;
    endfunction

    function automatic bit quiet();
        return exp_q.size() == 0 && if_scr.size() == 0 && mem_scr.size() == 0 && !if_act && !mem_act;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Predict one grant: duration from the planned latency, result from the planned data
    function automatic void grant(input bit pick_mem);
        int k, l, busy, ack;
        bit to;
        acc_t a;
        ack_t e;
        k    = k_model % NT;
        k_model++;
        l    = lat_a[k];
        to   = (l >= int'(MAXW));
        busy = to ? int'(MAXW) : l + 1;
        ack  = cyc + busy + 1;
        e.is_mem = pick_mem;
        e.err    = to;
        e.data   = to ? 32'h0 : rdat_a[k];
        e.cyc    = ack;
        exp_q.push_back(e);
        a.sel   = pick_mem;
        a.addr  = pick_mem ? mem_r.addr : if_addr_r;
        a.we    = pick_mem ? mem_r.we : 1'b0;
        a.start = cyc + 1;
        a.busy  = busy;
        acc_q.push_back(a);
        next_free = ack + 1;
        if (pick_mem) begin
            mem_gr = 1; mem_ack_c = ack;
        end else begin
            if_gr = 1; if_ack_c = ack;
        end
    endfunction

    // One cycle of requester behaviour plus the arbitration model
    task automatic step();
        bit pick_mem;
        if (if_act && if_gr && cyc == if_ack_c + 1) begin if_act = 0; if_gr = 0; end
        if (mem_act && mem_gr && cyc == mem_ack_c + 1) begin mem_act = 0; mem_gr = 0; end
        if (!if_act) begin
            if (if_scr.size() != 0) begin
                if_addr_r = if_scr.pop_front(); if_act = 1;
            end else if (rand_en && int'($urandom_range(0, 99)) < p_if) begin
                if_addr_r = $urandom(); if_act = 1;
            end
            if_req_drv = if_act;
        end
        if (!mem_act) begin
            if (mem_scr.size() != 0) begin
                mem_r = mem_scr.pop_front(); mem_act = 1;
            end else if (rand_en && int'($urandom_range(0, 99)) < p_mem) begin
                mem_r.we = 1'($urandom_range(0, 1)); mem_r.addr = $urandom(); mem_r.wd = $urandom();
                mem_act = 1;
            end
            mem_req_drv = mem_act;
        end
        // A granted requester may let go of Req early; the transfer must still finish
        if (rand_en && if_gr && $urandom_range(0, 99) < 10) if_req_drv = 0;
        if (rand_en && mem_gr && $urandom_range(0, 99) < 10) mem_req_drv = 0;
        if (cyc >= next_free && (if_act || mem_act)) begin
            pick_mem = mem_act && !(if_act && streak == 2);
            if (!pick_mem) streak = 0;
            else if (if_act && streak < 3) streak++;
            grant(pick_mem);
        end
        IF_Req    = if_req_drv;
        IF_Addr   = if_act ? if_addr_r : $urandom();
        MEM_Req   = mem_req_drv;
        MEM_We    = mem_act ? mem_r.we : 1'($urandom_range(0, 1));
        MEM_Addr  = mem_act ? mem_r.addr : $urandom();
        MEM_WData = mem_act ? mem_r.wd : $urandom();
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        do begin
            tick(); step(); n++;
        end while (!quiet() && n < budget);
        chk("phase_complete", 32'(quiet()), 32'd1);
    endtask

    function automatic void resync();
        exp_q.delete(); acc_q.delete();
        k_resp = k_model;
        exp_if_data = '0; exp_mem_data = '0;
        streak = 0; next_free = cyc;
        if_act = 0; mem_act = 0; if_gr = 0; mem_gr = 0;
        if_req_drv = 0; mem_req_drv = 0;
        mon_en = 1; resp_en = 1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(Mem_Valid), 32'd0);
        chk({tag, "_sel"}, 32'(Mem_Sel), 32'd0);
        chk({tag, "_acks_err"}, {29'd0, IF_Ack, MEM_Ack, Err}, 32'd0);
        chk({tag, "_if_data"}, IF_Data, 32'd0);
        chk({tag, "_mem_rdata"}, MEM_RData, 32'd0);
    endtask

    // Memory responder: checks each transfer's bus view and answers per the latency plan
    initial begin : responder
        acc_t cur;
        bit   in_x, rdy;
        int   rcnt, rk;
        cur = '0; in_x = 0; rcnt = 0; rk = 0;
        forever begin
            @(posedge CLK);
            #2;
            if (!resp_en) begin
                in_x = 0;
            end else begin
                if (Mem_Valid) begin
                    if (!in_x) begin
                        in_x = 1; rcnt = 0; rk = k_resp % NT; k_resp++;
                        chk("valid_expected", 32'(acc_q.size() != 0), 32'd1);
                        if (acc_q.size() != 0) begin
                            cur = acc_q.pop_front();
                            chk("valid_start_cycle", 32'(cyc), 32'(cur.start));
                            chk("mem_sel", 32'(Mem_Sel), 32'(cur.sel));
                        end
                    end
                    chk("mem_addr", Mem_Addr, cur.addr);
                    chk("mem_we", 32'(Mem_We), 32'(cur.we));
                    rdy = (rcnt == lat_a[rk]);
                    Mem_Ready = rdy;
                    Mem_RData = rdy ? rdat_a[rk] : $urandom();
                    rcnt++;
                end else begin
                    if (in_x) begin
                        chk("valid_cycles", 32'(rcnt), 32'(cur.busy));
                        in_x = 0;
                    end
                    Mem_Ready = 1'($urandom_range(0, 1));
                    Mem_RData = $urandom();
                end
                chk("mem_wdata", Mem_WData, MEM_WData);
            end
        end
    end

    // Ack monitor: acks only when predicted; data registers hold between transfers
    initial begin : monitor
        ack_t e;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    chk("if_ack", 32'(IF_Ack), 32'(!e.is_mem));
                    chk("mem_ack", 32'(MEM_Ack), 32'(e.is_mem));
                    chk("err", 32'(Err), 32'(e.err));
                    if (e.is_mem) exp_mem_data = e.data;
                    else exp_if_data = e.data;
                end else begin
                    chk("no_ack_no_err", {29'd0, IF_Ack, MEM_Ack, Err}, 32'd0);
                end
                chk("if_data", IF_Data, exp_if_data);
                chk("mem_rdata", MEM_RData, exp_mem_data);
            end
        end
    end

    initial begin : stimulus
        mreq_t m;
        RST_N = 0; IF_Req = 0; IF_Addr = '0; MEM_Req = 0; MEM_We = 0;
        MEM_Addr = '0; MEM_WData = '0; Mem_Ready = 0; Mem_RData = '0;
        exp_if_data = '0; exp_mem_data = '0;
        if_act = 0; mem_act = 0; if_gr = 0; mem_gr = 0; if_req_drv = 0; mem_req_drv = 0;
        if_ack_c = 0; mem_ack_c = 0; if_addr_r = '0; mem_r = '0;
        for (int i = 0; i < NT; i++) begin
            lat_a[i] = rand_lat();
            rdat_a[i] = $urandom();
        end

        repeat (3) tick();
        check_reset_outputs("reset");
        resync();
        RST_N = 1;
        step();

        // Single fetch, memory ready at once
        set_xfer(0, 0, 32'h00A00093);
        if_scr.push_back(32'h0000_0040);
        run_idle(50);

        // Store with three wait states
        set_xfer(0, 3, 32'h0BAD_F00D);
        m.we = 1; m.addr = 32'h0000_0100; m.wd = 32'hDEAD_BEEF;
        mem_scr.push_back(m);
        run_idle(50);

        // Both requesters busy back to back: fairness pattern
        for (int i = 0; i < 12; i++) set_xfer(i, 0, $urandom());
        for (int i = 0; i < 6; i++) begin
            if_scr.push_back(32'h200 + 32'(4 * i));
            m.we = 0; m.addr = 32'h1000 + 32'(4 * i); m.wd = $urandom();
            mem_scr.push_back(m);
        end
        run_idle(200);

        // Wait-state boundaries: last legal wait, then IF and MEM timeouts
        set_xfer(0, int'(MAXW) - 1, 32'hCAFE_F00D);
        set_xfer(1, 200, 32'h1111_1111);
        if_scr.push_back(32'h300);
        if_scr.push_back(32'h304);
        run_idle(100);
        set_xfer(0, 200, 32'h2222_2222);
        m.we = 0; m.addr = 32'h400; m.wd = 32'h0;
        mem_scr.push_back(m);
        run_idle(100);

        // Reset in the middle of a waiting fetch
        mon_en = 0; resp_en = 0;
        Mem_Ready = 0; MEM_Req = 0; IF_Req = 1; IF_Addr = 32'h80;
        tick();
        chk("rst_pre_valid1", 32'(Mem_Valid), 32'd1);
        tick();
        chk("rst_pre_valid2", 32'(Mem_Valid), 32'd1);
        RST_N = 0;
        tick();
        check_reset_outputs("mid_busy_reset");
        resync();
        set_xfer(0, 0, 32'h1357_9BDF);
        if_scr.push_back(32'h80);
        RST_N = 1;
        step();
        run_idle(50);

        // Random traffic
        rand_en = 1;
        repeat (3000) begin
            tick(); step();
        end
        rand_en = 0;
        run_idle(300);
        repeat (3) tick();
        chk("accesses_drained", 32'(acc_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
